// File: rtl/tsn_pkt_pkg.sv
// Shared packet-line definitions for the TSN ingress/egress ports:
// line flags, widths, PCB address split and legal frame sizes.
package tsn_pkt_pkg;

  localparam int LINE_W      = 134;
  localparam int BUFID_W     = 9;
  localparam int LINE_CNT_W  = 7;
  localparam int PCB_ADDR_W  = BUFID_W + LINE_CNT_W;
  localparam int TSNTAG_W    = 48;
  localparam int TSNTAG_LSB  = 80;

  localparam logic [1:0] FLAG_HEAD = 2'b01;
  localparam logic [1:0] FLAG_MID  = 2'b11;
  localparam logic [1:0] FLAG_TAIL = 2'b10;

  localparam int MIN_FRAME_B = 64;
  localparam int MAX_FRAME_B = 1518;

  // PCB line address: buffer id in the upper bits, line offset below.
  function automatic logic [PCB_ADDR_W-1:0] pcb_addr(input logic [BUFID_W-1:0]    bufid,
                                                     input logic [LINE_CNT_W-1:0] line);
    return {bufid, line};
  endfunction

endpackage

// File: rtl/nrp_bufid_prefetch.sv
// One-entry free-bufid prefetch: requests a bufid from the PCB whenever none
// is held, latches the grant, and releases it only when the owner consumes it.
module nrp_bufid_prefetch
  import tsn_pkt_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               bufid_ack_i,
  input  logic [BUFID_W-1:0] bufid_i,
  input  logic               consume_i,
  output logic               bufid_rd_o,
  output logic               held_o,
  output logic [BUFID_W-1:0] bufid_o
);

  logic               held_q, held_d;
  logic               rd_q, rd_d;
  logic [BUFID_W-1:0] bufid_q, bufid_d;

  // Only an ack against an outstanding request is taken, so a stray second
  // ack cannot overwrite a bufid that is already in use.
  always_comb begin
    held_d  = held_q;
    bufid_d = bufid_q;
    if (consume_i) begin
      held_d = 1'b0;
    end else if (rd_q && bufid_ack_i) begin
      held_d  = 1'b1;
      bufid_d = bufid_i;
    end
    rd_d = ~held_d;
  end

  // Holding register and registered request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      held_q  <= 1'b0;
      rd_q    <= 1'b0;
      bufid_q <= '0;
    end else begin
      held_q  <= held_d;
      rd_q    <= rd_d;
      bufid_q <= bufid_d;
    end
  end

  assign bufid_rd_o = rd_q;
  assign held_o     = held_q;
  assign bufid_o    = bufid_q;

endmodule

// File: rtl/network_receive_port.sv
// Ingress packet writer: stores packet lines in the PCB under a prefetched
// bufid and emits a {tsntag, bufid} descriptor per good frame.
// Optional build macro NRP_LEN_CHECK_EN: drop runt (<64 B) and oversize
// (>1518 B) frames at the tail; otherwise only the 128-line limit applies.
//
//  state    | meaning
//  IDLE     | waiting for a head line
//  WRITE    | writing lines of an accepted frame into the held bufid
//  DISCARD  | dropping lines until the tail of a rejected frame
module network_receive_port
  import tsn_pkt_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            iv_cfg_finish,
  input  logic [LINE_W-1:0]     iv_pkt_data,
  input  logic                  i_pkt_data_wr,
  output logic                  o_pkt_bufid_rd,
  input  logic [BUFID_W-1:0]    iv_pkt_bufid,
  input  logic                  i_pkt_bufid_ack,
  output logic [LINE_W-1:0]     ov_pkt_data,
  output logic [PCB_ADDR_W-1:0] ov_pkt_waddr,
  output logic                  o_pkt_wr,
  output logic [TSNTAG_W-1:0]   ov_tsntag,
  output logic [BUFID_W-1:0]    ov_bufid,
  output logic                  o_descriptor_wr,
  input  logic                  i_descriptor_ack,
  output logic                  o_pkt_cnt_pulse,
  output logic                  o_pkt_discard_pulse,
  output logic [1:0]            nrp_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_DISCARD = 2'd2
  } nrp_state_e;

  nrp_state_e              state_q, state_d;
  logic [LINE_CNT_W-1:0]   line_q, line_d, line_wr;
  logic                    full_q, full_d;
  logic                    wr_q, wr_d;
  logic [LINE_W-1:0]       data_q, data_d;
  logic [PCB_ADDR_W-1:0]   waddr_q, waddr_d;
  logic [TSNTAG_W-1:0]     tag_q, tag_d;
  logic [TSNTAG_W-1:0]     desc_tag_q, desc_tag_d;
  logic [BUFID_W-1:0]      desc_bufid_q, desc_bufid_d;
  logic                    desc_stage_q;
  logic                    desc_wr_q, desc_wr_d;
  logic                    cnt_q, cnt_d;
  logic                    disc_q, disc_d;

  logic [1:0]              flag;
  logic                    is_head, is_mid, is_tail, is_single;
  logic                    cfg_ok, slot_free, len_ok;
  logic                    start, do_write, consume;
  logic                    held;
  logic [BUFID_W-1:0]      held_bufid;

  nrp_bufid_prefetch u_prefetch (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .bufid_ack_i (i_pkt_bufid_ack),
    .bufid_i     (iv_pkt_bufid),
    .consume_i   (consume),
    .bufid_rd_o  (o_pkt_bufid_rd),
    .held_o      (held),
    .bufid_o     (held_bufid)
  );

  assign flag      = iv_pkt_data[LINE_W-1 -: 2];
  assign is_head   = i_pkt_data_wr && (flag == FLAG_HEAD);
  assign is_mid    = i_pkt_data_wr && (flag == FLAG_MID);
  assign is_tail   = i_pkt_data_wr && (flag == FLAG_TAIL);
  assign is_single = i_pkt_data_wr && (flag == 2'b00);
  assign cfg_ok    = (iv_cfg_finish == 2'b11);
  // An ack in the same cycle as a tail frees the slot for that tail.
  assign slot_free = !desc_stage_q && (!desc_wr_q || i_descriptor_ack);

`ifdef NRP_LEN_CHECK_EN
  logic [11:0] frame_bytes;
  assign frame_bytes = {1'b0, line_q, 4'b0000} + {8'b0, iv_pkt_data[131:128]} + 12'd1;
  assign len_ok      = (frame_bytes >= 12'(MIN_FRAME_B)) && (frame_bytes <= 12'(MAX_FRAME_B));
`else
  assign len_ok = 1'b1;
`endif

  // Main FSM next state, PCB write request and descriptor load.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    full_d       = full_q;
    wr_d         = 1'b0;
    data_d       = data_q;
    waddr_d      = waddr_q;
    tag_d        = tag_q;
    desc_tag_d   = desc_tag_q;
    desc_bufid_d = desc_bufid_q;
    disc_d       = 1'b0;
    consume      = 1'b0;
    start        = 1'b0;
    do_write     = 1'b0;
    line_wr      = line_q;
    unique case (state_q)
      ST_IDLE: begin
        if (is_head) start = 1'b1;
        else if (is_single) disc_d = 1'b1;
      end
      ST_WRITE: begin
        if (is_head) begin
          start  = 1'b1;
          disc_d = 1'b1;
        end else if (is_mid || is_tail) begin
          if (full_q) begin
            // 129th line: frame too long, bufid stays with us.
            if (is_tail) begin
              disc_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DISCARD;
            end
          end else begin
            do_write = 1'b1;
            if (is_tail) begin
              state_d = ST_IDLE;
              if (slot_free && len_ok) begin
                consume      = 1'b1;
                desc_tag_d   = tag_q;
                desc_bufid_d = held_bufid;
              end else begin
                disc_d = 1'b1;
              end
            end
          end
        end
      end
      ST_DISCARD: begin
        if (is_head) begin
          start  = 1'b1;
          disc_d = 1'b1;
        end else if (is_tail) begin
          disc_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      if (cfg_ok && held) begin
        state_d  = ST_WRITE;
        tag_d    = iv_pkt_data[TSNTAG_LSB +: TSNTAG_W];
        line_wr  = '0;
        do_write = 1'b1;
      end else begin
        state_d = ST_DISCARD;
      end
    end
    if (do_write) begin
      wr_d             = 1'b1;
      data_d           = iv_pkt_data;
      waddr_d          = pcb_addr(held_bufid, line_wr);
      {full_d, line_d} = {1'b0, line_wr} + (LINE_CNT_W+1)'(1);
    end
  end

  // Descriptor valid: raised one cycle after the load stage, held until ack.
  always_comb begin
    desc_wr_d = desc_wr_q;
    if (desc_wr_q && i_descriptor_ack) desc_wr_d = 1'b0;
    if (desc_stage_q) desc_wr_d = 1'b1;
    cnt_d = desc_wr_q && i_descriptor_ack;
  end

  // State, write pipeline and descriptor registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      line_q       <= '0;
      full_q       <= 1'b0;
      wr_q         <= 1'b0;
      data_q       <= '0;
      waddr_q      <= '0;
      tag_q        <= '0;
      desc_tag_q   <= '0;
      desc_bufid_q <= '0;
      desc_stage_q <= 1'b0;
      desc_wr_q    <= 1'b0;
      cnt_q        <= 1'b0;
      disc_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      full_q       <= full_d;
      wr_q         <= wr_d;
      data_q       <= data_d;
      waddr_q      <= waddr_d;
      tag_q        <= tag_d;
      desc_tag_q   <= desc_tag_d;
      desc_bufid_q <= desc_bufid_d;
      desc_stage_q <= consume;
      desc_wr_q    <= desc_wr_d;
      cnt_q        <= cnt_d;
      disc_q       <= disc_d;
    end
  end

  assign ov_pkt_data         = data_q;
  assign ov_pkt_waddr        = waddr_q;
  assign o_pkt_wr            = wr_q;
  assign ov_tsntag           = desc_tag_q;
  assign ov_bufid            = desc_bufid_q;
  assign o_descriptor_wr     = desc_wr_q;
  assign o_pkt_cnt_pulse     = cnt_q;
  assign o_pkt_discard_pulse = disc_q;
  assign nrp_state           = state_q;

endmodule
